// File: rtl/seq_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: state encodings and the default pattern.
// The default pattern is also referenced by the detector benches.
package seq_pattern_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_SHIFT = 3'b001,
    ST_GAP   = 3'b010,
    ST_DONE  = 3'b011
  } state_e;

  localparam logic [4:0] SEQ_DEFAULT_PAT = 5'b11001;

endpackage

// File: rtl/seq_pattern_tx_shifter.sv
// W-bit load/shift register with bit counter; exposes the MSB and a last-bit flag.
// Load has priority over shift so a back-to-back reload on the last bit restarts cleanly.
module pattern_shifter #(
  parameter int W = 5
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] load_val,
  output logic         msb,
  output logic         last
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]  shreg_q, shreg_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;

  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    if (load) begin
      shreg_d   = load_val;
      bit_cnt_d = '0;
    end else if (shift) begin
      shreg_d   = {shreg_q[W-2:0], 1'b0};
      bit_cnt_d = bit_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign msb  = shreg_q[W-1];
  assign last = (bit_cnt_q == CW'(W - 1));

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a latched W-bit pattern MSB-first, reps times, with GAP idle cycles between copies.
// Outputs decode registered state only; start is ignored unless idle.
module seq_pattern_tx
  import seq_pattern_tx_pkg::*;
#(
  parameter int             W           = 5,
  parameter logic [W-1:0]   DEFAULT_PAT = W'(SEQ_DEFAULT_PAT),
  parameter int             GAP         = 2,
  parameter int             CNT_W       = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic [W-1:0]     pat,
  input  logic [CNT_W-1:0] reps,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] REP_ONE  = CNT_W'(1);
  localparam logic [2:0]       GAP_LAST = 3'((GAP > 0) ? GAP - 1 : 0);

  state_e           state_q, state_d;
  logic [W-1:0]     pat_q, pat_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [2:0]       gap_cnt_q, gap_cnt_d;

  logic         sh_load, sh_shift, sh_msb, sh_last;
  logic [W-1:0] sh_load_val;

  pattern_shifter #(.W(W)) u_shifter (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (sh_load),
    .shift    (sh_shift),
    .load_val (sh_load_val),
    .msb      (sh_msb),
    .last     (sh_last)
  );

  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    rep_d       = rep_q;
    rep_cnt_d   = rep_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    sh_load     = 1'b0;
    sh_shift    = 1'b0;
    sh_load_val = pat_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sh_load     = 1'b1;
          sh_load_val = (pat == '0) ? DEFAULT_PAT : pat;
          pat_d       = sh_load_val;
          rep_d       = (reps == '0) ? REP_ONE : reps;
          rep_cnt_d   = '0;
          state_d     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sh_shift = 1'b1;
        if (sh_last) begin
          rep_cnt_d = rep_cnt_q + REP_ONE;
          if (rep_cnt_q + REP_ONE == rep_q) begin
            state_d = ST_DONE;
          end else if (GAP > 0) begin
            gap_cnt_d = '0;
            state_d   = ST_GAP;
          end else begin
            // Back-to-back copy: reload overrides the shift on this edge.
            sh_load = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          sh_load = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          gap_cnt_d = gap_cnt_q + 3'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      pat_q     <= '0;
      rep_q     <= '0;
      rep_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      rep_q     <= rep_d;
      rep_cnt_q <= rep_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign valid = (state_q == ST_SHIFT);
  assign out   = valid & sh_msb;
  assign busy  = (state_q == ST_SHIFT) || (state_q == ST_GAP) || (state_q == ST_DONE);
  assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: two instances (GAP=2 and GAP=0) share stimulus; a scoreboard
// of expected {out,valid,busy,done} per cycle is built from the transmit rules and drained by a monitor.
module tb_seq_pattern_tx;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       start;
  logic [4:0] pat;
  logic [3:0] reps;
  logic       out0, valid0, busy0, done0;
  logic       out1, valid1, busy1, done1;

  logic [3:0] exp0[$];
  logic [3:0] exp1[$];
  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  seq_pattern_tx #(.W(5), .DEFAULT_PAT(5'b11001), .GAP(2), .CNT_W(4)) dut_gap2 (
    .CLK(CLK), .RESET(RESET), .start(start), .pat(pat), .reps(reps),
    .out(out0), .valid(valid0), .busy(busy0), .done(done0)
  );

  seq_pattern_tx #(.W(5), .DEFAULT_PAT(5'b11001), .GAP(0), .CNT_W(4)) dut_gap0 (
    .CLK(CLK), .RESET(RESET), .start(start), .pat(pat), .reps(reps),
    .out(out1), .valid(valid1), .busy(busy1), .done(done1)
  );

  // Reference: expected per-cycle output tuples {out,valid,busy,done} for one accepted transfer.
  task automatic push_tx(input logic [4:0] p, input logic [3:0] r);
    logic [4:0] v;
    int rq;
    v  = (p == 5'd0) ? 5'b11001 : p;
    rq = (r == 4'd0) ? 1 : int'(r);
    for (int c = 0; c < rq; c++) begin
      for (int b = 4; b >= 0; b--) begin
        exp0.push_back({v[b], 3'b110});
        exp1.push_back({v[b], 3'b110});
      end
      if (c < rq - 1) begin
        repeat (2) exp0.push_back(4'b0010);
      end
    end
    exp0.push_back(4'b0011);
    exp1.push_back(4'b0011);
  endtask

  // Monitor: during reset outputs must be zero; otherwise every active cycle pops one expectation.
  initial begin
    logic [3:0] a0, a1, e;
    forever begin
      @(negedge CLK or posedge RESET);
      if (RESET) begin
        #1;
        exp0.delete();
        exp1.delete();
        checks++;
        if ({out0, valid0, busy0, done0, out1, valid1, busy1, done1} != 8'd0) begin
          failures++;
          $display("FAIL reset_outputs actual gap2=%b gap0=%b required 0000", {out0, valid0, busy0, done0}, {out1, valid1, busy1, done1});
        end
      end else begin
        a0 = {out0, valid0, busy0, done0};
        a1 = {out1, valid1, busy1, done1};
        if (exp0.size() > 0 || a0 != 4'd0) begin
          checks++;
          if (exp0.size() == 0) begin
            failures++;
            $display("FAIL gap2_unexpected t=%0t actual=%b required idle 0000", $time, a0);
          end else begin
            e = exp0.pop_front();
            if (a0 != e) begin
              failures++;
              $display("FAIL gap2_stream t=%0t actual=%b required=%b", $time, a0, e);
            end
          end
        end
        if (exp1.size() > 0 || a1 != 4'd0) begin
          checks++;
          if (exp1.size() == 0) begin
            failures++;
            $display("FAIL gap0_unexpected t=%0t actual=%b required idle 0000", $time, a1);
          end else begin
            e = exp1.pop_front();
            if (a1 != e) begin
              failures++;
              $display("FAIL gap0_stream t=%0t actual=%b required=%b", $time, a1, e);
            end
          end
        end
      end
    end
  end

  // Start pulse sampled at the next edge; the inputs are then scrambled to show they are latched.
  task automatic send(input logic [4:0] p, input logic [3:0] r);
    @(posedge CLK);
    #1;
    start = 1'b1;
    pat   = p;
    reps  = r;
    @(posedge CLK);
    #1;
    push_tx(p, r);
    start = 1'b0;
    pat   = 5'($urandom);
    reps  = 4'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp0.size() > 0 || exp1.size() > 0) && n < 300) begin
      @(posedge CLK);
      n++;
    end
    if (n >= 300) begin
      $display("FAIL wait_idle timeout actual queued=%0d/%0d required 0/0", exp0.size(), exp1.size());
      $fatal(1, "transfer did not complete");
    end
    @(posedge CLK);
  endtask

  initial begin
    RESET = 1'b1;
    start = 1'b0;
    pat   = '0;
    reps  = '0;
    repeat (3) @(posedge CLK);
    #3 RESET = 1'b0;
    repeat (2) @(posedge CLK);

    send(5'b11001, 4'd1);
    wait_idle();
    send(5'b10110, 4'd3);
    wait_idle();
    send(5'b00000, 4'd0);
    wait_idle();
    send(5'b11001, 4'd2);
    wait_idle();

    // Start re-pulsed mid-shift with a different pattern must be ignored.
    send(5'b10011, 4'd1);
    @(posedge CLK);
    #1;
    start = 1'b1;
    pat   = 5'b11111;
    reps  = 4'd3;
    @(posedge CLK);
    #1;
    start = 1'b0;
    wait_idle();

    // Asynchronous reset once the third bit is on the line.
    send(5'b10110, 4'd2);
    @(posedge CLK);
    @(posedge CLK);
    #3 RESET = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    #3 RESET = 1'b0;
    repeat (2) @(posedge CLK);
    send(5'b10110, 4'd1);
    wait_idle();

    for (int i = 0; i < 10; i++) begin
      logic [4:0] rp;
      logic [3:0] rr;
      rp = (i == 3) ? 5'd0 : 5'($urandom);
      rr = 4'($urandom_range(0, 4));
      send(rp, rr);
      wait_idle();
    end

    repeat (3) @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
